// File: rtl/hdmi_tmds_transmitter_if.sv
// Pixel request/response bus between the TMDS transmitter and its upstream frame source.
interface hdmi_tmds_transmitter_if;
    logic        pix_req;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        frame_start;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;

    modport master (
        output pix_req, pix_x, pix_y, frame_start,
        input  pix_r, pix_g, pix_b
    );

    modport slave (
        input  pix_req, pix_x, pix_y, frame_start,
        output pix_r, pix_g, pix_b
    );
endinterface

// File: rtl/hdmi_tmds_transmitter.sv
// Raster timing generator plus three DC-balanced TMDS encoders producing 10-bit symbols
// for a downstream 10:1 serialiser.
module hdmi_tmds_transmitter #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst,
    hdmi_tmds_transmitter_if.master        pix,
    output logic [9:0]                     tmds_ch0,
    output logic [9:0]                     tmds_ch1,
    output logic [9:0]                     tmds_ch2
);
    localparam int unsigned CW      = 12;
    localparam int unsigned DW      = 8;
    localparam int unsigned SW      = 10;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [SW-1:0] CTL_00 = 10'b1101010100;
    localparam logic [SW-1:0] CTL_01 = 10'b0010101011;
    localparam logic [SW-1:0] CTL_10 = 10'b0101010100;
    localparam logic [SW-1:0] CTL_11 = 10'b1010101011;

    logic [CW-1:0] x_q;
    logic [CW-1:0] y_q;
    logic          de0;
    logic          hs0;
    logic          vs0;

    // Stage 0: raster counters
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (x_q == CW'(H_TOTAL - 1)) begin
            x_q <= '0;
            y_q <= (y_q == CW'(V_TOTAL - 1)) ? '0 : y_q + CW'(1);
        end else begin
            x_q <= x_q + CW'(1);
        end
    end

    assign de0 = (x_q < CW'(H_ACTIVE)) && (y_q < CW'(V_ACTIVE));
    assign hs0 = (x_q >= CW'(H_ACTIVE + H_FP)) && (x_q < CW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs0 = (y_q >= CW'(V_ACTIVE + V_FP)) && (y_q < CW'(V_ACTIVE + V_FP + V_SYNC));

    assign pix.pix_req     = de0;
    assign pix.pix_x       = x_q;
    assign pix.pix_y       = y_q;
    assign pix.frame_start = (x_q == '0) && (y_q == '0);

    logic                 de1;
    logic                 hs1;
    logic                 vs1;
    logic [2:0][DW-1:0]   px1;

    // Stage 1: physical sync levels and pixel capture; data outside active video is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            de1 <= 1'b0;
            hs1 <= 1'b0;
            vs1 <= 1'b0;
            px1 <= '0;
        end else begin
            de1 <= de0;
            hs1 <= hs0 ? HS_POL : ~HS_POL;
            vs1 <= vs0 ? VS_POL : ~VS_POL;
            if (de0) begin
                px1 <= {pix.pix_r, pix.pix_g, pix.pix_b};
            end
        end
    end

    // Stage 2: one encoder per channel; index 0 = blue (carries sync), 1 = green, 2 = red
    for (genvar ch = 0; ch < 3; ch++) begin : g_enc
        logic [DW-1:0]     din;
        logic [1:0]        ctl;
        logic [3:0]        n1;
        logic [3:0]        n1m;
        logic              use_xnor;
        logic [8:0]        qm;
        logic signed [4:0] bal;
        logic signed [4:0] cnt_q;
        logic signed [4:0] cnt_d;
        logic [SW-1:0]     sym_q;
        logic [SW-1:0]     sym_d;

        assign din = px1[ch];
        assign ctl = (ch == 0) ? {vs1, hs1} : 2'b00;

        always_comb begin
            sym_d = CTL_00;
            cnt_d = '0;
            n1    = '0;
            n1m   = '0;
            for (int i = 0; i < 8; i++) begin
                n1 = n1 + 4'(din[i]);
            end
            use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !din[0]);
            qm[0]    = din[0];
            for (int i = 1; i < 8; i++) begin
                qm[i] = use_xnor ? ~(qm[i-1] ^ din[i]) : (qm[i-1] ^ din[i]);
            end
            qm[8] = ~use_xnor;
            for (int i = 0; i < 8; i++) begin
                n1m = n1m + 4'(qm[i]);
            end
            // N1 - N0 in two's complement; modular 5-bit subtraction gives the right bits
            bal = 5'(n1m) - 5'(4'd8 - n1m);

            if (!de1) begin
                unique case (ctl)
                    2'b00:   sym_d = CTL_00;
                    2'b01:   sym_d = CTL_01;
                    2'b10:   sym_d = CTL_10;
                    default: sym_d = CTL_11;
                endcase
            end else if ((cnt_q == 5'sd0) || (n1m == 4'd4)) begin
                sym_d = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
                cnt_d = qm[8] ? (cnt_q + bal) : (cnt_q - bal);
            end else if (((cnt_q > 5'sd0) && (n1m > 4'd4)) || ((cnt_q < 5'sd0) && (n1m < 4'd4))) begin
                sym_d = {1'b1, qm[8], ~qm[7:0]};
                cnt_d = cnt_q + (qm[8] ? 5'sd2 : 5'sd0) - bal;
            end else begin
                sym_d = {1'b0, qm[8], qm[7:0]};
                cnt_d = cnt_q + bal - (qm[8] ? 5'sd0 : 5'sd2);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
                sym_q <= CTL_00;
            end else begin
                cnt_q <= cnt_d;
                sym_q <= sym_d;
            end
        end
    end

    assign tmds_ch0 = g_enc[0].sym_q;
    assign tmds_ch1 = g_enc[1].sym_q;
    assign tmds_ch2 = g_enc[2].sym_q;
endmodule

// File: tb/tb_hdmi_tmds_transmitter.sv
// Scoreboard bench for hdmi_tmds_transmitter on an 8x5 raster: directed zero frames with
// hand-derived symbols, a mid-frame reset, then random frames against a reference encoder.
`timescale 1ns/1ps
module tb_hdmi_tmds_transmitter;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 2, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    localparam logic [9:0] CTL00 = 10'b1101010100;
    localparam logic [9:0] CTL01 = 10'b0010101011;
    localparam logic [9:0] CTL10 = 10'b0101010100;
    localparam logic [9:0] CTL11 = 10'b1010101011;
    localparam logic [9:0] ZA    = 10'b0100000000;
    localparam logic [9:0] ZB    = 10'b1111111111;

    typedef struct packed {
        logic            de;
        logic [2:0][9:0] sym;
        logic [2:0][7:0] dat;
        logic [11:0]     x;
        logic [11:0]     y;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] tmds_ch0, tmds_ch1, tmds_ch2;
    logic       drv_valid = 1'b0;
    logic [1:0] vp = 2'b00;
    exp_t       exp_q[$];
    exp_t       me;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         mx = 0, my = 0, since_rst = 0;
    int         cnt_m[3] = '{0, 0, 0};
    int         disp[3]  = '{0, 0, 0};

    hdmi_tmds_transmitter_if bus();

    hdmi_tmds_transmitter #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix(bus),
        .tmds_ch0(tmds_ch0),
        .tmds_ch1(tmds_ch1),
        .tmds_ch2(tmds_ch2)
    );

    always #5 clk = ~clk;

    // Marks which output cycles carry a scoreboarded position (2-cycle latency)
    always @(posedge clk) begin
        if (rst) vp <= 2'b00;
        else     vp <= {vp[0], drv_valid};
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0][9:0] ctl_sym(input int x, input int y);
        logic [2:0][9:0] s;
        bit ha, va;
        ha = (x >= HA + HF) && (x < HA + HF + HS);
        va = (y >= VA + VF) && (y < VA + VF + VS);
        s[1] = CTL00;
        s[2] = CTL00;
        case ({va, ha})
            2'b00:   s[0] = CTL11;
            2'b01:   s[0] = CTL10;
            2'b10:   s[0] = CTL01;
            default: s[0] = CTL00;
        endcase
        return s;
    endfunction

    // All-zero line: cnt 0 -> -8 -> 2 -> -6 -> 4, restarting every line
    function automatic logic [2:0][9:0] zero_sym(input int x);
        logic [9:0] v;
        v = (x % 2 == 0) ? ZA : ZB;
        return {v, v, v};
    endfunction

    task automatic ref_enc(input logic [7:0] d, input int cin, output logic [9:0] sym, output int cout);
        logic [8:0] qm;
        int n1, ones, zeros;
        bit use_xnor;
        n1 = $countones(d);
        use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !use_xnor;
        ones  = $countones(qm[7:0]);
        zeros = 8 - ones;
        if (cin == 0 || ones == zeros) begin
            sym  = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            cout = cin + (qm[8] ? (ones - zeros) : (zeros - ones));
        end else if ((cin > 0 && ones > zeros) || (cin < 0 && zeros > ones)) begin
            sym  = {1'b1, qm[8], ~qm[7:0]};
            cout = cin + 2 * int'(qm[8]) + zeros - ones;
        end else begin
            sym  = {1'b0, qm[8], qm[7:0]};
            cout = cin + ones - zeros - (qm[8] ? 0 : 2);
        end
    endtask

    function automatic logic [7:0] tmds_dec(input logic [9:0] q);
        logic [7:0] v, d;
        v = q[9] ? ~q[7:0] : q[7:0];
        d[0] = v[0];
        for (int i = 1; i < 8; i++) d[i] = q[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        return d;
    endfunction

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        drv_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        mx = 0;
        my = 0;
        since_rst = 0;
        cnt_m = '{0, 0, 0};
    endtask

    // One pixel-clock cycle: check the timing outputs, drive the pixel, queue the expected symbols
    task automatic step(input bit rnd);
        exp_t e;
        logic [7:0] d[3];
        logic [9:0] s;
        int c;
        bit de;
        de = (mx < HA) && (my < VA);
        chk("pix_x", bus.pix_x, 12'(mx));
        chk("pix_y", bus.pix_y, 12'(my));
        chk("pix_req", 12'(bus.pix_req), 12'(de));
        chk("frame_start", 12'(bus.frame_start), 12'(mx == 0 && my == 0));
        if (since_rst < 2) begin
            chk("rst_ch0", 12'(tmds_ch0), 12'(CTL00));
            chk("rst_ch1", 12'(tmds_ch1), 12'(CTL00));
            chk("rst_ch2", 12'(tmds_ch2), 12'(CTL00));
        end
        for (int ch = 0; ch < 3; ch++) d[ch] = rnd ? 8'($urandom) : (de ? 8'h00 : 8'hFF);
        bus.pix_b = d[0];
        bus.pix_g = d[1];
        bus.pix_r = d[2];
        e.de  = de;
        e.dat = {d[2], d[1], d[0]};
        e.x   = 12'(mx);
        e.y   = 12'(my);
        if (!de) begin
            e.sym = ctl_sym(mx, my);
            cnt_m = '{0, 0, 0};
        end else if (rnd) begin
            for (int ch = 0; ch < 3; ch++) begin
                ref_enc(d[ch], cnt_m[ch], s, c);
                e.sym[ch] = s;
                cnt_m[ch] = c;
            end
        end else begin
            e.sym = zero_sym(mx);
        end
        exp_q.push_back(e);
        drv_valid = 1'b1;
        @(posedge clk);
        #1;
        since_rst++;
        mx++;
        if (mx == HT) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
        end
    endtask

    // Monitor: pop and compare whenever a scoreboarded position reaches the outputs
    always @(negedge clk) begin
        if (vp[1]) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard_underflow: got empty queue, want an entry (t=%0t)", $time);
            end else begin
                logic [9:0] act[3];
                me = exp_q.pop_front();
                act[0] = tmds_ch0;
                act[1] = tmds_ch1;
                act[2] = tmds_ch2;
                for (int ch = 0; ch < 3; ch++) begin
                    chk($sformatf("tmds_ch%0d@(%0d,%0d)", ch, me.x, me.y), 12'(act[ch]), 12'(me.sym[ch]));
                    if (me.de) begin
                        disp[ch] += 2 * $countones(act[ch]) - 10;
                        chk($sformatf("decode_ch%0d@(%0d,%0d)", ch, me.x, me.y),
                            12'(tmds_dec(act[ch])), 12'(me.dat[ch]));
                        chk($sformatf("disp_range_ch%0d", ch),
                            12'(disp[ch] >= -10 && disp[ch] <= 10), 12'd1);
                    end else begin
                        disp[ch] = 0;
                    end
                end
            end
        end else begin
            disp = '{0, 0, 0};
        end
    end

    initial begin
        bus.pix_r = 8'h00;
        bus.pix_g = 8'h00;
        bus.pix_b = 8'h00;
        do_reset(3);
        repeat (2 * HT * VT) step(1'b0);
        repeat (HT + 2) step(1'b0);
        do_reset(1);
        repeat (3 * HT * VT) step(1'b1);
        drv_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drain", 12'(exp_q.size()), 12'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
